// File: rtl/weight_fetch_pkg.sv
// Shared constants for the weight ROM fetcher: kernel geometry, counter widths and FSM encoding.
package weight_fetch_pkg;

    localparam int unsigned KERNEL_WIDTH = 72;  // 9 weights x 8 bits
    localparam int unsigned NUM_KERNELS  = 12;  // kernels per group
    localparam int unsigned TAG_WIDTH    = 4;   // kernel index within a group
    localparam int unsigned CNT_WIDTH    = 12;  // holds 255 * 12 kernels

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/wfetch_fifo2.sv
// Two-entry FIFO with a registered head: slot0 is always the oldest entry and drives data_o.
module wfetch_fifo2
    import weight_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = KERNEL_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Next-state: shift toward slot0 on pop, fill the first free slot on push.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (do_push) begin
                    slot0_d = data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    slot0_d = data_i;
                end else if (do_push) begin
                    slot1_d = data_i;
                    count_d = 2'd2;
                end else if (do_pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (do_pop) begin
                    slot0_d = slot1_q;
                    if (do_push) begin
                        slot1_d = data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign data_o  = slot0_q;
    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/weight_rom_fetch.sv
// Weight ROM fetcher: reads one kernel per ROM word for a layer and streams them out over
// valid/ready with group/layer tags. Optional stall counter under WEIGHT_FETCH_PERF_EN.
module weight_rom_fetch
    import weight_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_layer_base,
    input  logic [7:0]              i_num_groups,
    output logic                    o_rom_en,
    output logic [ADDR_WIDTH-1:0]   o_rom_addr,
    input  logic [KERNEL_WIDTH-1:0] i_rom_data,
    output logic                    o_kernel_valid,
    input  logic                    i_kernel_ready,
    output logic [KERNEL_WIDTH-1:0] o_kernel_data,
    output logic [TAG_WIDTH-1:0]    o_kernel_idx,
    output logic                    o_group_last,
    output logic                    o_layer_last,
    output logic                    o_busy,
    output logic                    o_done
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    output logic [15:0]             o_stall_cnt
`endif
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
    logic [TAG_WIDTH-1:0]  idx_q, idx_d;
    logic                  inflight_q;

    logic                    start_acc;
    logic                    issue;
    logic                    pop;
    logic [2:0]              occ;
    logic [1:0]              fifo_count;
    logic                    fifo_valid;
    logic [KERNEL_WIDTH-1:0] fifo_data;

    assign start_acc = i_start && (state_q == StIdle);
    assign pop       = fifo_valid && i_kernel_ready;

    // Credit counts the slot freed by a pop this cycle, so a steady stream sustains one
    // read per cycle while occupancy (FIFO + in flight) never exceeds two.
    assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == StFetch) && (issue_cnt_q != total_q) && (occ < 3'd2);

    // Next-state for the FSM, address/issue counters and output-side tag counters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        total_d     = total_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        idx_d       = idx_q;

        if (issue) begin
            addr_d      = addr_q + 1'b1;
            issue_cnt_d = issue_cnt_q + 1'b1;
        end

        if (pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
            idx_d     = (idx_q == TAG_WIDTH'(NUM_KERNELS - 1)) ? '0 : idx_q + 1'b1;
        end

        if (start_acc) begin
            addr_d      = i_layer_base;
            total_d     = CNT_WIDTH'(i_num_groups) * CNT_WIDTH'(NUM_KERNELS);
            issue_cnt_d = '0;
            out_cnt_d   = '0;
            idx_d       = '0;
        end

        case (state_q)
            StIdle: begin
                if (start_acc) state_d = StFetch;
            end
            StFetch: begin
                if (total_q == '0) begin
                    state_d = StDone;
                end else if (issue && (issue_cnt_d == total_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave as the last entry is handed over so o_done follows it directly.
                if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and counter state; a reset drops any read still in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            total_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            idx_q       <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            idx_q       <= idx_d;
            inflight_q  <= issue;
        end
    end

    // ROM word returns one cycle after issue and is pushed straight into the FIFO.
    wfetch_fifo2 #(
        .WIDTH (KERNEL_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (inflight_q),
        .data_i  (i_rom_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .valid_o (fifo_valid)
    );

    assign o_rom_en       = issue;
    assign o_rom_addr     = addr_q;
    assign o_kernel_valid = fifo_valid;
    assign o_kernel_data  = fifo_data;
    assign o_kernel_idx   = idx_q;
    assign o_group_last   = fifo_valid && (idx_q == TAG_WIDTH'(NUM_KERNELS - 1));
    assign o_layer_last   = fifo_valid && (out_cnt_q == (total_q - 1'b1));
    assign o_busy         = (state_q == StFetch) || (state_q == StDrain);
    assign o_done         = (state_q == StDone);

`ifdef WEIGHT_FETCH_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the consumer holds off a valid kernel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (fifo_valid && !i_kernel_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_weight_rom_fetch.sv
// Bench for weight_rom_fetch: queue-based model of the kernel stream plus directed scenarios.
module tb_weight_rom_fetch;

    logic        clk;
    logic        rstn;
    logic        i_start;
    logic [13:0] i_layer_base;
    logic [7:0]  i_num_groups;
    logic        o_rom_en;
    logic [13:0] o_rom_addr;
    logic [71:0] rom_q;
    logic        o_kernel_valid;
    logic        i_kernel_ready;
    logic [71:0] o_kernel_data;
    logic [3:0]  o_kernel_idx;
    logic        o_group_last;
    logic        o_layer_last;
    logic        o_busy;
    logic        o_done;
`ifdef WEIGHT_FETCH_PERF_EN
    logic [15:0] o_stall_cnt;
`endif

    weight_rom_fetch #(
        .ADDR_WIDTH (14)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_start        (i_start),
        .i_layer_base   (i_layer_base),
        .i_num_groups   (i_num_groups),
        .o_rom_en       (o_rom_en),
        .o_rom_addr     (o_rom_addr),
        .i_rom_data     (rom_q),
        .o_kernel_valid (o_kernel_valid),
        .i_kernel_ready (i_kernel_ready),
        .o_kernel_data  (o_kernel_data),
        .o_kernel_idx   (o_kernel_idx),
        .o_group_last   (o_group_last),
        .o_layer_last   (o_layer_last),
        .o_busy         (o_busy),
        .o_done         (o_done)
`ifdef WEIGHT_FETCH_PERF_EN
        ,
        .o_stall_cnt    (o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [71:0] exp_data_q[$];
    logic [3:0]  exp_idx_q[$];
    bit          exp_gl_q[$];
    bit          exp_ll_q[$];
    logic [13:0] exp_addr_q[$];

    int          issued = 0;
    int          handshakes = 0;
    logic [13:0] first_addr = '0;
    logic [13:0] last_addr = '0;
    bit          done_exp = 1'b0;
    bit          done_chk_en = 1'b1;
    int          rdy_mode = 0;
    int          rcyc = 0;
    bit          rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] rom_word(input logic [13:0] a);
        logic [15:0] aa;
        aa = {2'b00, a};
        return {aa[7:0], 16'(aa * 16'h9E37), ~aa, aa ^ 16'h5A5A, aa + 16'h1234};
    endfunction

    // Synchronous ROM: data valid the cycle after the enable.
    always @(posedge clk) begin
        if (o_rom_en) rom_q <= rom_word(o_rom_addr);
    end

    // Ready pattern generator (mode 2 leaves ready to the directed test).
    always @(posedge clk) begin
        #1;
        rcyc++;
        if (rdy_mode == 0) i_kernel_ready = 1'b1;
        else if (rdy_mode == 1) i_kernel_ready = rdy_pat[rcyc % 4];
    end

    // Expected stream for one layer.
    task automatic load_model(input logic [13:0] base, input int groups);
        exp_data_q.delete(); exp_idx_q.delete(); exp_gl_q.delete();
        exp_ll_q.delete(); exp_addr_q.delete();
        for (int k = 0; k < groups * 12; k++) begin
            exp_addr_q.push_back(base + 14'(k));
            exp_data_q.push_back(rom_word(base + 14'(k)));
            exp_idx_q.push_back(4'(k % 12));
            exp_gl_q.push_back((k % 12) == 11);
            exp_ll_q.push_back(k == groups * 12 - 1);
        end
    endtask

    // Compare process: every cycle out of reset, DUT against model.
    always @(negedge clk) begin
        if (rstn) begin
            if (done_chk_en) chk("done_timing", 72'(o_done), 72'(done_exp));
            done_exp = 1'b0;
            if (o_rom_en) begin
                if (exp_addr_q.size() == 0) chk("rom_en_unexpected", 72'(o_rom_en), 72'(0));
                else chk("rom_addr", 72'(o_rom_addr), 72'(exp_addr_q.pop_front()));
                if (issued == 0) first_addr = o_rom_addr;
                last_addr = o_rom_addr;
                issued++;
            end
            if (o_kernel_valid) begin
                if (exp_data_q.size() == 0) begin
                    chk("valid_unexpected", 72'(o_kernel_valid), 72'(0));
                end else begin
                    chk("kernel_data", o_kernel_data, exp_data_q[0]);
                    chk("kernel_idx", 72'(o_kernel_idx), 72'(exp_idx_q[0]));
                    chk("group_last", 72'(o_group_last), 72'(exp_gl_q[0]));
                    chk("layer_last", 72'(o_layer_last), 72'(exp_ll_q[0]));
                    if (i_kernel_ready) begin
                        done_exp = exp_ll_q[0];
                        void'(exp_data_q.pop_front());
                        void'(exp_idx_q.pop_front());
                        void'(exp_gl_q.pop_front());
                        void'(exp_ll_q.pop_front());
                        handshakes++;
                    end
                end
            end else begin
                chk("flags_without_valid", 72'({o_group_last, o_layer_last}), 72'(0));
            end
            chk("outstanding_le2", 72'((issued - handshakes) <= 2), 72'(1));
        end
    end

    task automatic start_layer(input logic [13:0] base, input int groups);
        load_model(base, groups);
        issued = 0;
        handshakes = 0;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_layer_base = base;
        i_num_groups = 8'(groups);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_done) chk("done_timeout", 72'(o_done), 72'(1));
        chk("busy_low_at_done", 72'(o_busy), 72'(0));
        chk("model_drained", 72'(exp_data_q.size()), 72'(0));
        chk("addr_drained", 72'(exp_addr_q.size()), 72'(0));
        @(posedge clk); #1;
        chk("done_single_cycle", 72'(o_done), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int nd;
        int n;
        rstn = 1'b0;
        i_start = 1'b0;
        i_layer_base = '0;
        i_num_groups = '0;
        i_kernel_ready = 1'b1;
        rom_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 72'(o_kernel_valid), 72'(0));
        chk("rst_rom_en", 72'(o_rom_en), 72'(0));
        chk("rst_busy", 72'(o_busy), 72'(0));
        chk("rst_done", 72'(o_done), 72'(0));
        chk("rst_data", o_kernel_data, 72'(0));
        chk("rst_idx", 72'(o_kernel_idx), 72'(0));
        rstn = 1'b1;

        // 1: single group, ready always high
        start_layer(14'h0100, 1);
        lat = 1;
        while (!o_kernel_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_valid_latency", 72'(lat), 72'(3));
        chk("first_data_literal", o_kernel_data, 72'h003700FEFF5B5A1334);
        chk("first_idx_literal", 72'(o_kernel_idx), 72'(0));
        chk("first_addr_literal", 72'(first_addr), 72'(14'h0100));
        wait_done();
        chk("t1_handshakes", 72'(handshakes), 72'(12));
        chk("t1_last_addr", 72'(last_addr), 72'(14'h010B));

        // 2: two groups, ready 1,0,0,1 repeating
        rdy_mode = 1;
        start_layer(14'h0000, 2);
        wait_done();
        rdy_mode = 0;
        chk("t2_handshakes", 72'(handshakes), 72'(24));

        // 3: zero groups
        done_chk_en = 1'b0;
        start_layer(14'h0123, 0);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_busy) nb++;
            if (o_done) nd++;
            @(posedge clk); #1;
        end
        done_chk_en = 1'b1;
        chk("t3_busy_cycles", 72'(nb), 72'(1));
        chk("t3_done_pulses", 72'(nd), 72'(1));
        chk("t3_no_reads", 72'(issued), 72'(0));
        chk("t3_no_kernels", 72'(handshakes), 72'(0));

        // 4: address wrap
        start_layer(14'h3FFA, 1);
        wait_done();
        chk("t4_first_addr", 72'(first_addr), 72'(14'h3FFA));
        chk("t4_last_addr", 72'(last_addr), 72'(14'h0005));

        // 5: 20-cycle stall mid-layer
        start_layer(14'h0200, 2);
        n = 0;
        while (handshakes < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        rdy_mode = 2;
        @(posedge clk); #1;
        i_kernel_ready = 1'b0;
        repeat (20) @(posedge clk);
        chk("t5_outstanding_in_stall", 72'(issued - handshakes), 72'(2));
        #1;
        i_kernel_ready = 1'b1;
        rdy_mode = 0;
        wait_done();
        chk("t5_handshakes", 72'(handshakes), 72'(24));
`ifdef WEIGHT_FETCH_PERF_EN
        chk("t5_stall_cnt", 72'(o_stall_cnt), 72'(20));
`endif

        // 6: start while busy is ignored, then reset mid-fetch
        start_layer(14'h0400, 3);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_busy", 72'(o_busy), 72'(1));
        i_start = 1'b1;
        i_layer_base = 14'h0800;
        i_num_groups = 8'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 72'(o_kernel_valid), 72'(0));
        chk("t6_rst_rom_en", 72'(o_rom_en), 72'(0));
        chk("t6_rst_busy", 72'(o_busy), 72'(0));
        chk("t6_rst_done", 72'(o_done), 72'(0));
        chk("t6_rst_data", o_kernel_data, 72'(0));
        chk("t6_rst_tags", 72'({o_kernel_idx, o_group_last, o_layer_last}), 72'(0));
        exp_data_q.delete(); exp_idx_q.delete(); exp_gl_q.delete();
        exp_ll_q.delete(); exp_addr_q.delete();
        done_exp = 1'b0;
        issued = 0;
        handshakes = 0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle_after_rst", 72'({o_busy, o_done, o_kernel_valid}), 72'(0));
        start_layer(14'h0600, 1);
        wait_done();
        chk("t6_fresh_first_addr", 72'(first_addr), 72'(14'h0600));
        chk("t6_fresh_handshakes", 72'(handshakes), 72'(12));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
